// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: round-robin arbiter giving two requesters access to a synchronous RAM, an LED register and a switch port
module mem_bus_arbiter (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [1:0]  i_req0_cmd,
  input  logic [8:0]  i_req0_addr,
  input  logic [15:0] i_req0_wdata,
  input  logic [1:0]  i_req1_cmd,
  input  logic [8:0]  i_req1_addr,
  input  logic [15:0] i_req1_wdata,
  output logic        o_req0_ack,
  output logic [15:0] o_req0_rdata,
  output logic        o_req1_ack,
  output logic [15:0] o_req1_rdata,
  output logic [7:0]  o_ram_addr,
  output logic        o_ram_write,
  output logic [15:0] o_ram_din,
  input  logic [15:0] i_ram_dout,
  input  logic [7:0]  i_sw,
  output logic [7:0]  o_ledr,
  output logic        o_busy,
  output logic        o_owner
);
  typedef enum logic [1:0] {IDLE, ACCESS, READ_WAIT, DONE} state_t;
  state_t      r_state;
  logic        r_owner;
  logic        r_wr;
  logic [8:0]  r_addr;
  logic [15:0] r_wdata;
  logic        r_ram_write;
  logic        r_ack0;
  logic        r_ack1;
  logic [15:0] r_rdata0;
  logic [15:0] r_rdata1;
  logic [7:0]  r_ledr;
  logic        w_pend0;
  logic        w_pend1;
  logic        w_grant1;
  logic [1:0]  w_cmd;
  logic [8:0]  w_addr;
  logic [15:0] w_wdata;
  logic        w_finish;
  logic        w_load;
  logic [15:0] w_rd_val;
  // Request decode, round-robin choice and completion/read-data selection
  always_comb begin
    w_pend0  = (i_req0_cmd == 2'b01) || (i_req0_cmd == 2'b10);
    w_pend1  = (i_req1_cmd == 2'b01) || (i_req1_cmd == 2'b10);
    w_grant1 = w_pend1 && (!w_pend0 || !r_owner);
    w_cmd    = w_grant1 ? i_req1_cmd   : i_req0_cmd;
    w_addr   = w_grant1 ? i_req1_addr  : i_req0_addr;
    w_wdata  = w_grant1 ? i_req1_wdata : i_req0_wdata;
    w_finish = (r_state == READ_WAIT) || ((r_state == ACCESS) && (r_wr || r_addr[8]));
    w_load   = w_finish && !r_wr;
    w_rd_val = (r_state == READ_WAIT) ? i_ram_dout :
               (r_addr == 9'h140) ? {8'h00, i_sw} : 16'h0000;
  end
  // Transaction FSM: latch a grant in IDLE, perform the access, pulse ack in DONE
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= IDLE;
      r_owner     <= 1'b1;
      r_wr        <= 1'b0;
      r_addr      <= 9'h000;
      r_wdata     <= 16'h0000;
      r_ram_write <= 1'b0;
      r_ack0      <= 1'b0;
      r_ack1      <= 1'b0;
      r_rdata0    <= 16'h0000;
      r_rdata1    <= 16'h0000;
      r_ledr      <= 8'h00;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pend0 || w_pend1) begin
            r_state     <= ACCESS;
            r_owner     <= w_grant1;
            r_wr        <= (w_cmd == 2'b10);
            r_addr      <= w_addr;
            r_wdata     <= w_wdata;
            r_ram_write <= (w_cmd == 2'b10) && !w_addr[8];
          end
        end
        ACCESS: begin
          r_ram_write <= 1'b0;
          if (r_wr && (r_addr == 9'h100)) r_ledr <= r_wdata[7:0];
          r_state <= w_finish ? DONE : READ_WAIT;
        end
        READ_WAIT: r_state <= DONE;
        DONE: begin
          r_state <= IDLE;
          r_wr    <= 1'b0;
          r_addr  <= 9'h000;
          r_wdata <= 16'h0000;
        end
      endcase
      r_ack0 <= w_finish && !r_owner;
      r_ack1 <= w_finish && r_owner;
      if (w_load && !r_owner) r_rdata0 <= w_rd_val;
      if (w_load && r_owner) r_rdata1 <= w_rd_val;
    end
  end
  assign o_req0_ack   = r_ack0;
  assign o_req1_ack   = r_ack1;
  assign o_req0_rdata = r_rdata0;
  assign o_req1_rdata = r_rdata1;
  assign o_ram_addr   = r_addr[7:0];
  assign o_ram_write  = r_ram_write;
  assign o_ram_din    = r_wdata;
  assign o_ledr       = r_ledr;
  assign o_busy       = (r_state != IDLE);
  assign o_owner      = r_owner;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: transaction-timeline reference model checking the arbiter cycle by cycle
module tb_mem_bus_arbiter;
  typedef struct {logic [1:0] cmd; logic [8:0] addr; logic [15:0] wd;} txn_t;
  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  d_cmd [2];
  logic [8:0]  d_addr [2];
  logic [15:0] d_wd [2];
  logic        ack0, ack1, ram_write, busy, owner;
  logic [15:0] rd0, rd1, ram_din, ram_dout;
  logic [7:0]  ram_addr, ledr, sw;
  logic [15:0] ram [256];
  int n_vec = 0, n_err = 0, cyc = 0;
  txn_t q0[$], q1[$];
  bit   hold [2];
  int   gseq[$];
  bit          a_on;
  int          a_g, a_l, a_r, free_edge;
  logic [1:0]  a_cmd;
  logic [8:0]  a_addr;
  logic [15:0] a_wd;
  logic        m_owner;
  logic [15:0] m_rd [2];
  logic [7:0]  m_ledr;
  logic [15:0] m_mem [256];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_write) ram[ram_addr] <= ram_din;
    ram_dout <= ram[ram_addr];
  end

  mem_bus_arbiter dut (
    .i_clk(clk), .i_reset(rst),
    .i_req0_cmd(d_cmd[0]), .i_req0_addr(d_addr[0]), .i_req0_wdata(d_wd[0]),
    .i_req1_cmd(d_cmd[1]), .i_req1_addr(d_addr[1]), .i_req1_wdata(d_wd[1]),
    .o_req0_ack(ack0), .o_req0_rdata(rd0), .o_req1_ack(ack1), .o_req1_rdata(rd1),
    .o_ram_addr(ram_addr), .o_ram_write(ram_write), .o_ram_din(ram_din), .i_ram_dout(ram_dout),
    .i_sw(sw), .o_ledr(ledr), .o_busy(busy), .o_owner(owner)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic push(input int r, input logic [1:0] c, input logic [8:0] a, input logic [15:0] w);
    txn_t t;
    t.cmd = c; t.addr = a; t.wd = w;
    if (r == 0) q0.push_back(t); else q1.push_back(t);
  endtask

  task automatic model_reset();
    a_on = 0; free_edge = 0; m_owner = 1'b1; m_rd[0] = 0; m_rd[1] = 0; m_ledr = 0;
    q0.delete(); q1.delete();
    for (int r = 0; r < 2; r++) begin hold[r] = 0; d_cmd[r] = 0; d_addr[r] = 0; d_wd[r] = 0; end
  endtask

  task automatic reset_chk(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_ack0"}, ack0, 0);
    chk({tag, "_ack1"}, ack1, 0);
    chk({tag, "_ram_write"}, ram_write, 0);
    chk({tag, "_ram_addr"}, ram_addr, 0);
    chk({tag, "_ram_din"}, ram_din, 0);
    chk({tag, "_ledr"}, ledr, 0);
    chk({tag, "_rdata0"}, rd0, 0);
    chk({tag, "_rdata1"}, rd1, 0);
    chk({tag, "_owner"}, owner, 1);
  endtask

  // One cycle, entered and left at the falling edge: check outputs, advance requesters, decide next grant
  task automatic step();
    logic [1:0] e_ack;
    logic       e_wr, last, p0, p1;
    int         r;
    txn_t       t;
    last = a_on && (cyc == a_g + a_l - 1);
    if (last) begin
      if (a_cmd == 2'b01)
        m_rd[a_r] = !a_addr[8] ? m_mem[a_addr[7:0]] : (a_addr == 9'h140) ? {8'h00, sw} : 16'h0000;
      else if (!a_addr[8]) m_mem[a_addr[7:0]] = a_wd;
      else if (a_addr == 9'h100) m_ledr = a_wd[7:0];
    end
    e_ack = 2'b00;
    if (last) e_ack[a_r] = 1'b1;
    e_wr = a_on && (cyc == a_g) && (a_cmd == 2'b10) && !a_addr[8];
    chk("busy", busy, a_on);
    chk("owner", owner, m_owner);
    chk("ack0", ack0, e_ack[0]);
    chk("ack1", ack1, e_ack[1]);
    chk("ram_write", ram_write, e_wr);
    chk("ram_addr", ram_addr, a_on ? a_addr[7:0] : 8'h00);
    chk("ram_din", ram_din, a_on ? a_wd : 16'h0000);
    chk("rdata0", rd0, m_rd[0]);
    chk("rdata1", rd1, m_rd[1]);
    chk("ledr", ledr, m_ledr);
    if (last) a_on = 0;
    for (int k = 0; k < 2; k++) begin
      if (e_ack[k]) begin
        if (k == 0) void'(q0.pop_front()); else void'(q1.pop_front());
        hold[k] = 0;
        d_cmd[k] = 2'b00;
      end
      if (!hold[k] && ((k == 0) ? q0.size() : q1.size()) > 0) begin
        t = (k == 0) ? q0[0] : q1[0];
        d_cmd[k] = t.cmd; d_addr[k] = t.addr; d_wd[k] = t.wd;
        hold[k] = 1;
      end
    end
    if (!rst && !a_on && cyc + 1 >= free_edge) begin
      p0 = (d_cmd[0] == 2'b01) || (d_cmd[0] == 2'b10);
      p1 = (d_cmd[1] == 2'b01) || (d_cmd[1] == 2'b10);
      if (p0 || p1) begin
        r = (p0 && p1) ? (m_owner ? 0 : 1) : (p1 ? 1 : 0);
        a_on = 1; a_g = cyc + 1; a_r = r;
        a_cmd = d_cmd[r]; a_addr = d_addr[r]; a_wd = d_wd[r];
        a_l = (a_cmd == 2'b01 && !a_addr[8]) ? 3 : 2;
        free_edge = a_g + a_l + 1;
        m_owner = r[0];
        gseq.push_back(r);
      end
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic drain(input string tag, input int budget);
    int k = 0;
    while ((q0.size() > 0 || q1.size() > 0 || a_on) && k < budget) begin
      step();
      k++;
    end
    chk({tag, "_timeout"}, (q0.size() > 0 || q1.size() > 0 || a_on) ? 16'd1 : 16'd0, 16'd0);
    step();
  endtask

  task automatic sync_reset(input string tag);
    rst = 1'b1;
    #1;
    reset_chk(tag);
    model_reset();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int k;
    logic [8:0] ad;
    rst = 1'b1;
    sw = 8'h00;
    model_reset();
    for (int i = 0; i < 256; i++) m_mem[i] = 16'h0000;
    #1;
    reset_chk("por");
    @(negedge clk);
    rst = 1'b0;
    // populate the low RAM words every later read may touch
    for (int i = 0; i < 16; i++) push(i % 2, 2'b10, 9'(i), 16'($urandom));
    drain("init", 200);
    // write then read back through RAM
    push(0, 2'b10, 9'h005, 16'hABCD);
    push(0, 2'b01, 9'h005, 16'h0000);
    drain("rw", 50);
    chk("rdata0_abcd", rd0, 16'hABCD);
    // LED write and switch read
    push(1, 2'b10, 9'h100, 16'h12A5);
    drain("led", 50);
    chk("ledr_a5", ledr, 8'hA5);
    sw = 8'h3C;
    push(1, 2'b01, 9'h140, 16'h0000);
    drain("sw", 50);
    chk("rdata1_sw", rd1, 16'h003C);
    // unmapped I/O read
    push(0, 2'b01, 9'h180, 16'h0000);
    drain("io0", 50);
    chk("rdata0_zero", rd0, 16'h0000);
    chk("rdata1_kept", rd1, 16'h003C);
    // held command issues a second read; reserved command is never granted
    push(0, 2'b01, 9'h005, 16'h0000);
    push(0, 2'b01, 9'h005, 16'h0000);
    drain("hold", 50);
    chk("rdata0_again", rd0, 16'hABCD);
    d_cmd[0] = 2'b11;
    d_cmd[1] = 2'b11;
    repeat (6) step();
    chk("cmd11_busy", busy, 0);
    d_cmd[0] = 2'b00;
    d_cmd[1] = 2'b00;
    // continuous contention from reset alternates grants
    sync_reset("rst2");
    gseq.delete();
    for (int i = 0; i < 6; i++) begin
      push(0, 2'b10, 9'h020 + 9'(i), 16'h1000 + 16'(i));
      push(1, 2'b10, 9'h030 + 9'(i), 16'h2000 + 16'(i));
    end
    drain("rr", 200);
    chk("rr_count", 16'(gseq.size()), 16'd12);
    for (int i = 0; i < gseq.size(); i++) chk("rr_order", 16'(gseq[i]), 16'(i % 2));
    // randomized mixed traffic
    for (int b = 0; b < 4; b++) begin
      sw = 8'($urandom);
      for (int i = 0; i < 30; i++) begin
        k = $urandom_range(0, 9);
        ad = (k < 6) ? 9'($urandom_range(0, 15)) : (k == 6) ? 9'h100 : (k == 7) ? 9'h140 :
             (k == 8) ? {1'b1, 8'($urandom)} : 9'h180 + 9'($urandom_range(0, 127));
        push($urandom_range(0, 1), 2'($urandom_range(1, 2)), ad, 16'($urandom));
      end
      drain("rand", 1000);
    end
    // asynchronous reset during READ_WAIT abandons the read
    push(0, 2'b10, 9'h100, 16'h00F0);
    push(1, 2'b01, 9'h007, 16'h0000);
    k = 0;
    while (!(a_on && a_l == 3 && cyc == a_g + 1) && k < 40) begin
      step();
      k++;
    end
    chk("rw_reach", (k < 40) ? 16'd1 : 16'd0, 16'd1);
    chk("rw_busy", busy, 1);
    #1;
    rst = 1'b1;
    #1;
    reset_chk("async");
    model_reset();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    reset_chk("held");
    rst = 1'b0;
    repeat (5) step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
